// File: rtl/encode_8x3_seq.sv
// Sequential priority encoder: captures a request vector and streams out the
// index of each set bit, one per valid/ready transfer, then pulses done.
module encode_8x3_seq #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = 3,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    output logic [IDX_W:0]   remaining,
    output logic             done,
    output logic             load_err,
    output logic             state_dbg
);

    // Handshake: an index moves on any rising edge where out_valid && out_ready.
    // out/out_valid/remaining depend only on pending_q, never on inputs, and
    // stay stable while the consumer stalls.

    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("encode_8x3_seq: WIDTH must be in 2..8");
    end
    if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
        $error("encode_8x3_seq: IDX_W must equal $clog2(WIDTH)");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   pop_cnt;
    logic             xfer;
    logic             last_xfer;
    logic             load_ok;

    // Priority select: the last match in scan order wins, so scanning upward
    // picks the highest set bit and scanning downward picks the lowest.
    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) begin
                    sel_idx = IDX_W'(i);
                    sel_oh  = WIDTH'(1) << i;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    sel_idx = IDX_W'(i);
                    sel_oh  = WIDTH'(1) << i;
                end
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (IDX_W + 1)'(pending_q[i]);
        end
    end

    assign out_valid = |pending_q;
    assign out       = sel_idx;
    assign remaining = pop_cnt;
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (pop_cnt == (IDX_W + 1)'(1));
    // A new vector may replace the one whose final index leaves on this edge.
    assign load_ok   = load && ((state_q == IDLE) || last_xfer);

    always_comb begin
        pending_d  = pending_q;
        done_d     = last_xfer;
        load_err_d = load && !load_ok;
        if (xfer) begin
            pending_d = pending_q & ~sel_oh;
        end
        if (load_ok) begin
            pending_d = in;
        end
        state_d = (pending_d != '0) ? ENCODE : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    a_state_tracks_pending: assert property (
        @(posedge clk) disable iff (rst) (state_q == ENCODE) == (pending_q != '0));
    a_pulses_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(done_q && load_err_q));

endmodule

// File: tb/tb_encode_8x3_seq.sv
// Directed bench for encode_8x3_seq: one highest-first and one lowest-first
// instance, each scenario a task with inline comparisons.
module tb_encode_8x3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, out_ready;
    logic [7:0] in_v;
    logic [2:0] out_h;
    logic       valid_h, done_h, err_h, st_h;
    logic [3:0] rem_h;

    logic       load_l, rdy_l;
    logic [7:0] in_l;
    logic [2:0] out_l;
    logic       valid_l, done_l, err_l, st_l;
    logic [3:0] rem_l;

    int n_cmp = 0;
    int n_bad = 0;

    encode_8x3_seq #(.WIDTH(8), .IDX_W(3), .HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst(rst), .load(load), .in(in_v), .out_ready(out_ready),
        .out(out_h), .out_valid(valid_h), .remaining(rem_h), .done(done_h),
        .load_err(err_h), .state_dbg(st_h)
    );

    encode_8x3_seq #(.WIDTH(8), .IDX_W(3), .HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst(rst), .load(load_l), .in(in_l), .out_ready(rdy_l),
        .out(out_l), .out_valid(valid_l), .remaining(rem_l), .done(done_l),
        .load_err(err_l), .state_dbg(st_l)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; in_v = '0; out_ready = 1'b0;
        load_l = 1'b0; in_l = '0; rdy_l = 1'b0;
        #3;
        n_cmp++;
        if ({out_h, valid_h, rem_h} !== 8'h00) begin
            n_bad++; $display("FAIL reset_out: out=%0d valid=%b rem=%0d want 0/0/0", out_h, valid_h, rem_h);
        end
        n_cmp++;
        if ({done_h, err_h, st_h} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: done=%b err=%b st=%b want 0/0/0", done_h, err_h, st_h);
        end
        n_cmp++;
        if ({out_l, valid_l, rem_l, done_l, err_l, st_l} !== 11'h000) begin
            n_bad++; $display("FAIL reset_lo: out=%0d valid=%b rem=%0d want 0", out_l, valid_l, rem_l);
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        logic [2:0] exp_idx [4];
        exp_idx = '{3'd7, 3'd5, 3'd2, 3'd0};
        load = 1'b1; in_v = 8'b1010_0101; out_ready = 1'b1;
        tick;
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_h !== exp_idx[k] || valid_h !== 1'b1 || rem_h !== 4'(4 - k) || done_h !== 1'b0 || st_h !== 1'b1) begin
                n_bad++;
                $display("FAIL priority[%0d]: out=%0d valid=%b rem=%0d done=%b want out=%0d valid=1 rem=%0d done=0",
                         k, out_h, valid_h, rem_h, done_h, exp_idx[k], 4 - k);
            end
            tick;
        end
        n_cmp++;
        if (done_h !== 1'b1 || valid_h !== 1'b0 || out_h !== 3'd0 || rem_h !== 4'd0) begin
            n_bad++; $display("FAIL priority_done: done=%b valid=%b out=%0d rem=%0d want 1/0/0/0", done_h, valid_h, out_h, rem_h);
        end
        tick;
        n_cmp++;
        if (done_h !== 1'b0) begin
            n_bad++; $display("FAIL priority_done_width: done=%b want 0", done_h);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        load = 1'b1; in_v = 8'h80; out_ready = 1'b0;
        tick;
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_h !== 3'd7 || valid_h !== 1'b1 || rem_h !== 4'd1 || done_h !== 1'b0) begin
                n_bad++; $display("FAIL stall[%0d]: out=%0d valid=%b rem=%0d done=%b want 7/1/1/0", k, out_h, valid_h, rem_h, done_h);
            end
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (done_h !== 1'b1 || valid_h !== 1'b0) begin
            n_bad++; $display("FAIL stall_done: done=%b valid=%b want 1/0", done_h, valid_h);
        end
        tick;
    endtask

    task automatic test_load_err;
        load = 1'b1; in_v = 8'h03; out_ready = 1'b1;
        tick;
        load = 1'b0;
        n_cmp++;
        if (out_h !== 3'd1 || rem_h !== 4'd2) begin
            n_bad++; $display("FAIL busy_first: out=%0d rem=%0d want 1/2", out_h, rem_h);
        end
        tick;
        out_ready = 1'b0; load = 1'b1; in_v = 8'hFF;
        tick;
        load = 1'b0;
        n_cmp++;
        if (err_h !== 1'b1 || out_h !== 3'd0 || rem_h !== 4'd1 || valid_h !== 1'b1) begin
            n_bad++; $display("FAIL busy_err: err=%b out=%0d rem=%0d valid=%b want 1/0/1/1", err_h, out_h, rem_h, valid_h);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (err_h !== 1'b0 || done_h !== 1'b1 || valid_h !== 1'b0) begin
            n_bad++; $display("FAIL busy_end: err=%b done=%b valid=%b want 0/1/0", err_h, done_h, valid_h);
        end
        tick;
        n_cmp++;
        if (valid_h !== 1'b0 || done_h !== 1'b0) begin
            n_bad++; $display("FAIL busy_idle: valid=%b done=%b want 0/0", valid_h, done_h);
        end
    endtask

    task automatic test_back_to_back;
        load = 1'b1; in_v = 8'h01; out_ready = 1'b1;
        tick;
        n_cmp++;
        if (out_h !== 3'd0 || rem_h !== 4'd1 || valid_h !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: out=%0d rem=%0d valid=%b want 0/1/1", out_h, rem_h, valid_h);
        end
        in_v = 8'h41;
        tick;
        load = 1'b0;
        n_cmp++;
        if (done_h !== 1'b1 || err_h !== 1'b0 || out_h !== 3'd6 || rem_h !== 4'd2 || valid_h !== 1'b1) begin
            n_bad++; $display("FAIL b2b_switch: done=%b err=%b out=%0d rem=%0d valid=%b want 1/0/6/2/1",
                              done_h, err_h, out_h, rem_h, valid_h);
        end
        tick;
        n_cmp++;
        if (done_h !== 1'b0 || out_h !== 3'd0 || rem_h !== 4'd1) begin
            n_bad++; $display("FAIL b2b_second: done=%b out=%0d rem=%0d want 0/0/1", done_h, out_h, rem_h);
        end
        tick;
        out_ready = 1'b0;
        n_cmp++;
        if (done_h !== 1'b1 || valid_h !== 1'b0) begin
            n_bad++; $display("FAIL b2b_done: done=%b valid=%b want 1/0", done_h, valid_h);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        load = 1'b1; in_v = 8'hF0; out_ready = 1'b1;
        tick;
        load = 1'b0;
        tick;
        tick;
        n_cmp++;
        if (out_h !== 3'd5 || rem_h !== 4'd2) begin
            n_bad++; $display("FAIL rstmid_pre: out=%0d rem=%0d want 5/2", out_h, rem_h);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (valid_h !== 1'b0 || out_h !== 3'd0 || rem_h !== 4'd0 || st_h !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_async: valid=%b out=%0d rem=%0d st=%b want 0/0/0/0", valid_h, out_h, rem_h, st_h);
        end
        tick;
        rst = 1'b0; out_ready = 1'b0;
        tick;
        n_cmp++;
        if (done_h !== 1'b0 || valid_h !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_nodone: done=%b valid=%b want 0/0", done_h, valid_h);
        end
        load = 1'b1; in_v = 8'h00;
        tick;
        load = 1'b0;
        n_cmp++;
        if (valid_h !== 1'b0 || done_h !== 1'b0 || err_h !== 1'b0 || st_h !== 1'b0) begin
            n_bad++; $display("FAIL zero_load: valid=%b done=%b err=%b st=%b want 0/0/0/0", valid_h, done_h, err_h, st_h);
        end
        tick;
        n_cmp++;
        if (done_h !== 1'b0 || valid_h !== 1'b0) begin
            n_bad++; $display("FAIL zero_load_after: done=%b valid=%b want 0/0", done_h, valid_h);
        end
    endtask

    task automatic test_low_first;
        logic [2:0] exp_idx [3];
        exp_idx = '{3'd0, 3'd3, 3'd6};
        load_l = 1'b1; in_l = 8'b0100_1001; rdy_l = 1'b1;
        tick;
        load_l = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_l !== exp_idx[k] || rem_l !== 4'(3 - k) || valid_l !== 1'b1) begin
                n_bad++; $display("FAIL low_first[%0d]: out=%0d rem=%0d valid=%b want %0d/%0d/1",
                                  k, out_l, rem_l, valid_l, exp_idx[k], 3 - k);
            end
            tick;
        end
        n_cmp++;
        if (done_l !== 1'b1 || valid_l !== 1'b0) begin
            n_bad++; $display("FAIL low_first_done: done=%b valid=%b want 1/0", done_l, valid_l);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] vv;
        logic [7:0] seen;
        int         prev, cnt, guard;
        for (int v = 0; v < 256; v++) begin
            vv = 8'(v);
            load_l = 1'b1; in_l = vv; rdy_l = 1'b1;
            tick;
            load_l = 1'b0;
            seen = '0; prev = -1; cnt = 0; guard = 0;
            while (valid_l && guard < 9) begin
                n_cmp++;
                if (vv[out_l] !== 1'b1 || seen[out_l] !== 1'b0 || int'(out_l) <= prev ||
                    rem_l !== 4'($countones(vv) - cnt)) begin
                    n_bad++; $display("FAIL sweep_idx: in=%h out=%0d rem=%0d prev=%0d want rem=%0d",
                                      vv, out_l, rem_l, prev, $countones(vv) - cnt);
                end
                seen[out_l] = 1'b1;
                prev = int'(out_l);
                cnt++;
                guard++;
                tick;
            end
            n_cmp++;
            if (seen !== vv || valid_l !== 1'b0 || done_l !== (vv != 8'h00) || err_l !== 1'b0) begin
                n_bad++; $display("FAIL sweep_set: in=%h seen=%h valid=%b done=%b err=%b want seen=%h valid=0 done=%b err=0",
                                  vv, seen, valid_l, done_l, err_l, vv, vv != 8'h00);
            end
        end
        rdy_l = 1'b0;
    endtask

    initial begin
        test_reset;
        test_priority;
        test_stall;
        test_load_err;
        test_back_to_back;
        test_reset_mid;
        test_low_first;
        test_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
